// File: rtl/contador_pkg.sv
// Shared types and helpers for the button-driven display counter.
// Digit stepping serves both hex and packed-BCD arithmetic (see CONTADOR_BCD_MODE_EN).
package contador_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] HEX_MAX_DIGIT = 4'hF;

  typedef enum logic {
    ESTABLE   = 1'b0,
    VALIDANDO = 1'b1
  } deb_state_e;

  // Steps four packed digits by one, rippling carry/borrow across all of them.
  // With a max digit of F this is plain 16-bit modulo arithmetic.
  function automatic logic [15:0] paso_digitos(input logic [15:0] valor,
                                               input logic        subir,
                                               input logic [3:0]  max_digito);
    logic [15:0] res;
    logic        acarreo;
    logic [3:0]  dig;
    res     = valor;
    acarreo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig = valor[4*i +: 4];
      if (acarreo) begin
        if (subir) begin
          if (dig == max_digito) begin
            dig = 4'd0;
          end else begin
            dig     = dig + 4'd1;
            acarreo = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            dig = max_digito;
          end else begin
            dig     = dig - 4'd1;
            acarreo = 1'b0;
          end
        end
      end
      res[4*i +: 4] = dig;
    end
    return res;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// One push-button conditioner: 2-flop synchroniser, debounce FSM and a
// registered one-cycle pulse on each accepted press (release gives no pulse).
//
// state     | meaning
// ESTABLE   | debounced level matches the synchronised input
// VALIDANDO | input differs; counting stable cycles before accepting it
module antirrebote
  import contador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic boton_i,
  output logic pulso_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  deb_state_e    estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nivel_q, nivel_d;
  logic          pulso_q, pulso_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q   <= 2'b00;
      estado_q <= ESTABLE;
      cnt_q    <= '0;
      nivel_q  <= 1'b0;
      pulso_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], boton_i};
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      nivel_q  <= nivel_d;
      pulso_q  <= pulso_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    nivel_d  = nivel_q;
    case (estado_q)
      ESTABLE: begin
        if (sync_q[1] != nivel_q) begin
          cnt_d    = '0;
          estado_d = VALIDANDO;
        end
      end
      VALIDANDO: begin
        if (sync_q[1] == nivel_q) begin
          estado_d = ESTABLE;
        end else if (cnt_q == CNT_MAX) begin
          nivel_d  = sync_q[1];
          estado_d = ESTABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = ESTABLE;
    endcase
    pulso_d = nivel_d & ~nivel_q;
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/contador_valor_display.sv
// Up/down/clear counter feeding the 7-segment display value; wraps with a pulse.
// Define CONTADOR_BCD_MODE_EN for 4-digit packed BCD, otherwise 16-bit hex.
module contador_valor_display
  import contador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clkNexys2,
  input  logic        Reset,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnClear,
  output logic [15:0] numBinario,
  output logic        desbordamiento
);

`ifdef CONTADOR_BCD_MODE_EN
  localparam logic [3:0] MAX_DIGITO = BCD_MAX_DIGIT;
`else
  localparam logic [3:0] MAX_DIGITO = HEX_MAX_DIGIT;
`endif

  logic        inc_pulso, dec_pulso, clr_pulso;
  logic [15:0] valor_q, valor_d;
  logic        desb_q, desb_d;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk_i(clkNexys2), .rst_n_i(Reset), .boton_i(btnUp), .pulso_o(inc_pulso)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk_i(clkNexys2), .rst_n_i(Reset), .boton_i(btnDown), .pulso_o(dec_pulso)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clk_i(clkNexys2), .rst_n_i(Reset), .boton_i(btnClear), .pulso_o(clr_pulso)
  );

  always_ff @(posedge clkNexys2 or negedge Reset) begin
    if (!Reset) begin
      valor_q <= 16'h0000;
      desb_q  <= 1'b0;
    end else begin
      valor_q <= valor_d;
      desb_q  <= desb_d;
    end
  end

  // Clear wins outright; opposing steps in the same cycle cancel.
  always_comb begin
    valor_d = valor_q;
    desb_d  = 1'b0;
    if (clr_pulso) begin
      valor_d = 16'h0000;
    end else if (inc_pulso && !dec_pulso) begin
      valor_d = paso_digitos(valor_q, 1'b1, MAX_DIGITO);
      desb_d  = (valor_q == {4{MAX_DIGITO}});
    end else if (dec_pulso && !inc_pulso) begin
      valor_d = paso_digitos(valor_q, 1'b0, MAX_DIGITO);
      desb_d  = (valor_q == 16'h0000);
    end
  end

  assign numBinario     = valor_q;
  assign desbordamiento = desb_q;

endmodule
